// File: rtl/fg_fetch.sv
// Foreground fetch: raster-order SRAM read requester with a credit-limited
// show-ahead response FIFO feeding the compositing pipeline.
//
// state | meaning
// IDLE  | waiting for frame_start
// FETCH | issuing pixel reads in raster order while credit allows
// DRAIN | all reads issued; waiting for the remaining responses
module fg_fetch #(
  parameter int X_RES      = 800,
  parameter int Y_RES      = 600,
  parameter int PRECISION  = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        hold,
  input  logic signed [PRECISION:0]   offset_x,
  input  logic signed [PRECISION:0]   offset_y,
  output logic                        request_active,
  output logic signed [PRECISION:0]   request_x,
  output logic signed [PRECISION:0]   request_y,
  input  logic [15:0]                 request_data,
  input  logic                        request_ready,
  output logic [15:0]                 pixel_out,
  output logic                        pixel_valid,
  input  logic                        pixel_pop,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Discards can pile up across back-to-back restarts, so give them headroom.
  localparam int DW = CW + 4;
  localparam logic [PRECISION-1:0] X_LAST = PRECISION'(X_RES - 1);
  localparam logic [PRECISION-1:0] Y_LAST = PRECISION'(Y_RES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_nxt;
  logic done_nxt;

  logic [PRECISION-1:0]      cnt_x, cnt_y;
  logic signed [PRECISION:0] off_x_q, off_y_q;
  logic [CW-1:0]             inflight, fifo_count;
  logic [DW-1:0]             discard;
  logic [15:0]               mem [FIFO_DEPTH];
  logic [AW-1:0]             rd_ptr, wr_ptr;
  logic issue, last_pix, fifo_full, pop_en, push_en, drop_ovf, rsp_live;

  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign last_pix  = (cnt_x == X_LAST) && (cnt_y == Y_LAST);
  assign issue     = (state == FETCH) && !frame_start && !hold &&
                     (({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH));
  assign pop_en    = pixel_pop && (fifo_count != '0) && !frame_start;
  assign rsp_live  = request_ready && !frame_start && (discard == '0);
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push_en   = rsp_live && (!fifo_full || pop_en);
  assign drop_ovf  = rsp_live && fifo_full && !pop_en;

  assign pixel_valid = (fifo_count != '0);
  assign pixel_out   = pixel_valid ? mem[rd_ptr] : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (frame_start) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        FETCH: if (issue && last_pix) state_nxt = DRAIN;
        DRAIN: if (inflight == '0 && discard == '0) begin
                 state_nxt = IDLE;
                 done_nxt  = 1'b1;
               end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      request_active <= 1'b0;
      request_x      <= '0;
      request_y      <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      cnt_x          <= '0;
      cnt_y          <= '0;
      off_x_q        <= '0;
      off_y_q        <= '0;
      inflight       <= '0;
      discard        <= '0;
      fifo_count     <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
    end else begin
      frame_done     <= done_nxt;
      request_active <= issue;
      if (drop_ovf) overflow <= 1'b1;

      if (frame_start) begin
        off_x_q    <= offset_x;
        off_y_q    <= offset_y;
        cnt_x      <= '0;
        cnt_y      <= '0;
        inflight   <= '0;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        // A response landing now belongs to the old outstanding set; drop it.
        discard    <= discard + DW'(inflight) -
                      DW'(request_ready && (discard != '0 || inflight != '0));
      end else begin
        if (issue) begin
          request_x <= $signed({1'b0, cnt_x}) - off_x_q;
          request_y <= $signed({1'b0, cnt_y}) - off_y_q;
          if (cnt_x == X_LAST) begin
            cnt_x <= '0;
            cnt_y <= cnt_y + 1'b1;
          end else begin
            cnt_x <= cnt_x + 1'b1;
          end
        end

        if (issue && !push_en)                        inflight <= inflight + 1'b1;
        else if (!issue && push_en && inflight != '0) inflight <= inflight - 1'b1;

        if (request_ready && discard != '0) discard <= discard - 1'b1;

        if (push_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push_en) - CW'(pop_en);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= request_data;
  end

endmodule

// File: doc/fg_fetch.md
Name: fg_fetch

Overview:
- Requester side of the SRAM foreground read path: walks a frame in raster order and issues pixel read requests (request_active/request_x/request_y) to the SRAM wrapper.
- Collects the in-order responses (request_data/request_ready) into a small show-ahead FIFO that the compositing pipeline pops.
- Uses a credit scheme so that outstanding requests plus buffered pixels never exceed FIFO_DEPTH; the FIFO cannot overflow.
- The fg offset is applied here; out-of-range coordinates are still issued, and the wrapper answers them with black.

Parameters:
X_RES, 800, frame width in pixels
Y_RES, 600, frame height in pixels
PRECISION, 11, unsigned coordinate width; signed coordinates are PRECISION+1 bits
FIFO_DEPTH, 8, response buffer depth; power of two, at least 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
frame_start  in  1  one-cycle pulse that (re)starts a frame walk
hold  in  1  while high, no new requests are issued (yields SRAM slots to writers)
offset_x  in  PRECISION+1  signed fg x offset, latched on frame_start
offset_y  in  PRECISION+1  signed fg y offset, latched on frame_start
request_active  out  1  read request strobe to SRAM wrapper, registered
request_x  out  PRECISION+1  signed fg image x coordinate, registered
request_y  out  PRECISION+1  signed fg image y coordinate, registered
request_data  in  16  response pixel (RGB565)
request_ready  in  1  response valid; responses return in request order
pixel_out  out  16  FIFO head pixel (show-ahead)
pixel_valid  out  1  FIFO non-empty
pixel_pop  in  1  consume head pixel
frame_done  out  1  one-cycle pulse when the last response of a frame has been written
overflow  out  1  sticky error flag: response arrived with the FIFO full

Behaviour:
- Reset (async): state IDLE; request_active, request_x, request_y, frame_done, overflow = 0; FIFO empty (pixel_valid 0, pixel_out 0); inflight = 0; discard = 0; cnt_x = cnt_y = 0.
- States:
  - IDLE: frame_start -> FETCH.
  - FETCH: after the last pixel is issued -> DRAIN.
  - DRAIN: when inflight == 0 and discard == 0 -> IDLE, pulsing frame_done for 1 cycle.
- frame_start, any state:
  - Latch offsets; cnt_x = cnt_y = 0; flush the FIFO.
  - discard += inflight (responses still outstanding are dropped); inflight = 0.
  - Go to FETCH. No request is issued in the frame_start cycle.
- Issue rule: in FETCH, a request is issued when hold == 0 and (fifo_count + inflight) < FIFO_DEPTH.
  - On issue, the next edge sets request_active = 1, request_x = {0,cnt_x} - offset_x and request_y = {0,cnt_y} - offset_y, with PRECISION+1-bit two's-complement wraparound.
  - Otherwise request_active = 0; request_x/y hold their values.
- Counter advance on issue:
  - cnt_x increments; at X_RES-1 it wraps to 0 and cnt_y increments.
  - Issuing (X_RES-1, Y_RES-1) moves the FSM to DRAIN.
- Inflight accounting:
  - +1 per issue, -1 per counted response; both in the same cycle leaves it unchanged.
  - A decrement at 0 must not occur; if it does, hold at 0.
- Response handling on request_ready:
  - If discard > 0: discard -= 1 and the data is dropped.
  - Else if the FIFO is full: set overflow and drop the data.
  - Else: push request_data and decrement inflight.
- request_ready and frame_start in the same cycle: the response is dropped and counted into the discard, i.e. discard = inflight_before - 1 (the response is one of the in-flight ones).
- Pop: pixel_pop with pixel_valid removes the head. pixel_pop while empty is ignored. Push and pop in the same cycle leaves the count unchanged, including when full.
- pixel_out is 0 when empty.
- hold mid-frame pauses issuing only; responses and pops continue.
- request_ready in IDLE with discard == 0 is pushed if there is room; otherwise overflow is set.
- Latency: frame_start at edge N gives the first request_active at edge N+1. Throughput is 1 request/cycle while credit is available.

Test Plan:
- X_RES=4, Y_RES=2, DEPTH=8, offsets 0; model wrapper with 4-cycle echo returning x*16+y; pixel_pop held 1 -> 8 requests on 8 consecutive cycles, (0,0),(1,0)..(3,1); pixel_out sequence 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31; frame_done pulses once after the 8th push.
- Same setup, pixel_pop held 0, DEPTH=4 -> exactly 4 requests issued, then request_active stays 0; fifo full, overflow 0. Pop one -> exactly one further request follows.
- offset_x=2, offset_y=-1 -> first request is (-2,1), last is (1,2); signed wrap is correct.
- frame_start asserted 2 cycles into a frame (2 in flight) -> those 2 late responses are discarded; FIFO receives only new-frame pixels starting at (0,0); exactly one frame_done.
- hold=1 for 5 cycles mid-frame -> no request_active during hold; issuing resumes at the saved cnt_x/cnt_y with no skipped or repeated coordinates.
- Reset asserted mid-frame with responses pending -> all outputs 0 immediately (async); after release, stray request_ready with the FIFO empty is pushed; frame_start then runs a clean frame.
